bnn_feature_sequencer: RTL and testbench
========================================

Name: bnn_feature_sequencer

Overview:
Host-side front end for the sequential BNN classifiers (rospinor_seq-based wrappers such as the pendigits designs).
- Accepts one quantised feature per beat over a valid/ready stream and assembles the packed feature vector.
- Restarts the sequential classifier, waits its fixed evaluation latency, and captures the prediction.
- Returns the class index on a valid/ready result stream.

Parameters:
- FEAT_CNT, 16, features per sample.
- FEAT_BITS, 4, bits per feature.
- CLASS_CNT, 10, number of classes; sets the prediction width $clog2(CLASS_CNT).
- LATENCY, 64, cycles the classifier needs after reset release before its prediction is final; must be >= 1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  sequencer can accept a feature beat.
- in_data  in  FEAT_BITS  feature value, in feature-index order 0..FEAT_CNT-1.
- features  out  FEAT_CNT*FEAT_BITS  packed vector to classifier; feature i at bits [i*FEAT_BITS +: FEAT_BITS].
- bnn_rst  out  1  reset to classifier.
- prediction  in  $clog2(CLASS_CNT)  classifier output.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_class  out  $clog2(CLASS_CNT)  captured class index.
- out_error  out  1  captured prediction >= CLASS_CNT.

Behaviour:
- Reset (async, active-high): state LOAD, beat index 0, shadow vector 0, features 0, wait counter 0, out_valid 0, out_class 0, out_error 0, in_ready 0 while rst high.
- bnn_rst = rst OR (state == RESTART). It is the only combinational path from rst, so the classifier is held in reset whenever the sequencer is.
- State LOAD: in_ready = 1.
  - On in_valid & in_ready, in_data is written into shadow slot idx.
  - If idx < FEAT_CNT-1: idx increments.
  - If idx == FEAT_CNT-1: idx returns to 0, features is loaded from the full shadow vector (including this beat) on the same edge, and state moves to RESTART.
  - features never changes outside this edge.
- State RESTART: exactly 1 cycle. in_ready 0, bnn_rst 1. Next state WAIT with the counter loaded to LATENCY-1.
- State WAIT: in_ready 0, bnn_rst 0, counter decrements each cycle.
  - When counter == 0, on that edge: out_class <= prediction, out_error <= (prediction >= CLASS_CNT), out_valid <= 1, state moves to OUTPUT.
  - WAIT lasts exactly LATENCY cycles.
- State OUTPUT: out_valid 1, out_class and out_error stable, in_ready 0.
  - On out_ready: out_valid <= 0 and state moves to LOAD.
  - LOAD accepts the next beat on the following cycle, never in the same cycle as the handshake.
- Latency: last feature accepted at edge E. RESTART occupies cycle E..E+1. Prediction is sampled at edge E+1+LATENCY. out_valid is high from edge E+1+LATENCY, i.e. LATENCY+1 edges after the last beat.
- in_valid in non-LOAD states is ignored with no state change. in_data is don't-care when in_valid is low.
- out_ready while out_valid is low has no effect.
- Reset asserted mid-load, in WAIT, or in OUTPUT aborts everything: the partial sample is discarded and any pending result is dropped (out_valid falls asynchronously).
- out_error is informational only; out_class holds the raw prediction bits.
- Non-power-of-two CLASS_CNT: an out-of-range code is reported via out_error and is not clamped.

Test Plan:
- Reset, then stream features i = 0..15 with value i (in_valid held high) -> in_ready high for 16 cycles; features = 0xFEDCBA9876543210 from the edge of beat 15; bnn_rst high for exactly 1 cycle.
- Classifier model driving prediction = 7, LATENCY = 64 -> out_valid rises exactly 65 edges after beat 15; out_class = 7; out_error = 0; in_ready stays 0 throughout.
- Hold out_ready low for 10 cycles after out_valid -> out_valid and out_class stay stable. Raise out_ready -> out_valid drops next edge; in_ready = 1 on the following cycle.
- Drive prediction = 12 (CLASS_CNT = 10) -> out_class = 12, out_error = 1.
- Insert in_valid gaps (every other cycle) during load -> still exactly 16 accepted beats; features unchanged until the 16th.
- Assert rst after 9 beats, then again during WAIT -> outputs return to reset values immediately; bnn_rst high during reset; a following full 16-beat load produces a correct, fresh result.

Source files
------------

// File: rtl/bnn_feature_sequencer.sv
// Streams FEAT_CNT quantised features into a packed vector, pulses the classifier reset,
// waits LATENCY cycles, then returns the captured class index over a valid/ready stream.
module bnn_feature_sequencer #(
  parameter int FEAT_CNT  = 16,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 10,
  parameter int LATENCY   = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FEAT_BITS-1:0]              in_data,
  output logic [FEAT_CNT*FEAT_BITS-1:0]     features,
  output logic                              bnn_rst,
  input  logic [$clog2(CLASS_CNT)-1:0]      prediction,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]      out_class,
  output logic                              out_error
);

  localparam int PW = $clog2(CLASS_CNT);
  localparam int IW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(FEAT_CNT - 1);
  localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY - 1);
  localparam logic [PW:0]   CLASS_LIM = (PW + 1)'(CLASS_CNT);

  typedef enum logic [1:0] {S_LOAD, S_RESTART, S_WAIT, S_OUTPUT} state_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [FEAT_CNT*FEAT_BITS-1:0]   shadow_q, shadow_d;
  logic [FEAT_CNT*FEAT_BITS-1:0]   features_q, features_d;
  logic                            in_ready_q, in_ready_d;
  logic                            out_valid_q, out_valid_d;
  logic [PW-1:0]                   out_class_q, out_class_d;
  logic                            out_error_q, out_error_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    features_d  = features_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_error_d = out_error_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          for (int i = 0; i < FEAT_CNT; i++) begin
            if (idx_q == IW'(i)) shadow_d[i*FEAT_BITS +: FEAT_BITS] = in_data;
          end
          if (idx_q == IDX_LAST) begin
            // Publish the complete vector, including this last beat, on the same edge.
            idx_d      = '0;
            features_d = shadow_d;
            state_d    = S_RESTART;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_RESTART: begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          out_class_d = prediction;
          out_error_d = ({1'b0, prediction} >= CLASS_LIM);
          out_valid_d = 1'b1;
          state_d     = S_OUTPUT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase

    // Registered so ready stays low through reset and the first cycle after it.
    in_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      features_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      features_q  <= features_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_error_q <= out_error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign features  = features_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_error = out_error_q;
  assign bnn_rst   = rst | (state_q == S_RESTART);

endmodule

// File: tb/tb_bnn_feature_sequencer.sv
// Directed bench for bnn_feature_sequencer: table of full samples plus reset-abort sequences.
module tb_bnn_feature_sequencer;

  localparam int LAT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [63:0] features;
  logic        bnn_rst;
  logic [3:0]  prediction;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_class;
  logic        out_error;

  bnn_feature_sequencer #(
    .FEAT_CNT (16),
    .FEAT_BITS(4),
    .CLASS_CNT(10),
    .LATENCY  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .features  (features),
    .bnn_rst   (bnn_rst),
    .prediction(prediction),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_error (out_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] vec;
    logic [3:0]  pred;
    bit          gaps;
    int          hold;
    logic [3:0]  exp_class;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers nbeats of vec; features must keep prev until the final beat lands.
  task automatic load_beats(input logic [63:0] vec, input int nbeats, input bit gaps,
                            input logic [63:0] prev);
    int beat = 0;
    int cyc  = 0;
    bit ph   = 1'b0;
    bit acc;
    bit feat_ok = 1'b1;
    while (beat < nbeats && cyc < 400) begin
      in_valid = gaps ? ph : 1'b1;
      ph = !ph;
      in_data = in_valid ? vec[beat*4 +: 4] : 4'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (features !== prev) feat_ok = 1'b0;
      @(posedge clk);
      #1;
      if (acc) beat++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("beats_accepted", 64'(beat), 64'(nbeats));
    chk("features_hold_during_load", 64'(feat_ok), 64'd1);
    if (nbeats == 16) begin
      chk("features_loaded", features, vec);
      chk("in_ready_low_after_last", 64'(in_ready), 64'd0);
      chk("bnn_rst_restart", 64'(bnn_rst), 64'd1);
    end
  endtask

  // Called 1ns after the last-beat edge; models a classifier that settles after LAT cycles.
  task automatic wait_result(input logic [63:0] vec, input logic [3:0] pred, input int hold,
                             input logic [3:0] exp_class, input bit exp_err);
    int n = 0;
    bit rst_ok = 1'b1;
    bit rdy_ok = 1'b1;
    bit stable = 1'b1;
    prediction = pred ^ 4'h5;
    in_valid = 1'b1;
    while (!out_valid && n < 200) begin
      in_data = 4'($urandom);
      @(posedge clk);
      #1;
      n++;
      if (bnn_rst) rst_ok = 1'b0;
      if (in_ready) rdy_ok = 1'b0;
      if (n == LAT) prediction = pred;
    end
    chk("out_valid_latency", 64'(n), 64'(LAT + 1));
    chk("bnn_rst_single_pulse", 64'(rst_ok), 64'd1);
    chk("in_ready_low_in_wait", 64'(rdy_ok), 64'd1);
    chk("out_class", 64'(out_class), 64'(exp_class));
    chk("out_error", 64'(out_error), 64'(exp_err));
    chk("features_stable_after_load", features, vec);
    prediction = ~pred;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (!out_valid || out_class !== exp_class || out_error !== exp_err || in_ready)
        stable = 1'b0;
    end
    chk("output_stable_under_backpressure", 64'(stable), 64'd1);
    chk("in_ready_low_in_handshake", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_drops", 64'(out_valid), 64'd0);
    chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
    chk("features_kept_after_output", features, vec);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_features"}, features, 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_class"}, 64'(out_class), 64'd0);
    chk({tag, "_out_error"}, 64'(out_error), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_bnn_rst"}, 64'(bnn_rst), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk({tag, "_bnn_rst_release"}, 64'(bnn_rst), 64'd0);
    chk({tag, "_in_ready_after_release"}, 64'(in_ready), 64'd0);
  endtask

  vec_t        tbl[5];
  logic [63:0] prev;

  initial begin
    tbl[0] = '{64'hFEDC_BA98_7654_3210, 4'd7,  1'b0, 10, 4'd7,  1'b0};
    tbl[1] = '{64'h0123_4567_89AB_CDEF, 4'd12, 1'b0, 0,  4'd12, 1'b1};
    tbl[2] = '{64'hA5A5_5A5A_F00F_1234, 4'd9,  1'b1, 3,  4'd9,  1'b0};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b1, 1,  4'd10, 1'b1};
    tbl[4] = '{64'h0000_0000_0000_0000, 4'd0,  1'b0, 0,  4'd0,  1'b0};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 4'h0;
    out_ready  = 1'b0;
    prediction = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_features", features, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_class", 64'(out_class), 64'd0);
    chk("rst_out_error", 64'(out_error), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_bnn_rst", 64'(bnn_rst), 64'd1);
    rst = 1'b0;
    #1;
    chk("release_bnn_rst", 64'(bnn_rst), 64'd0);

    prev = 64'd0;
    for (int r = 0; r < 5; r++) begin
      load_beats(tbl[r].vec, 16, tbl[r].gaps, prev);
      wait_result(tbl[r].vec, tbl[r].pred, tbl[r].hold, tbl[r].exp_class, tbl[r].exp_err);
      prev = tbl[r].vec;
    end

    // Abort after 9 beats; the next sample must start fresh from slot 0.
    load_beats(64'h1111_2222_3333_4444, 9, 1'b0, prev);
    do_reset("rst_midload");
    prev = 64'd0;
    load_beats(64'h8421_0F1E_2D3C_4B5A, 16, 1'b0, prev);
    wait_result(64'h8421_0F1E_2D3C_4B5A, 4'd3, 2, 4'd3, 1'b0);
    prev = 64'h8421_0F1E_2D3C_4B5A;

    // Abort during the evaluation wait.
    load_beats(64'h1357_9BDF_0246_8ACE, 16, 1'b0, prev);
    repeat (20) @(posedge clk);
    #1;
    do_reset("rst_wait");
    prev = 64'd0;
    load_beats(64'h7766_5544_3322_1100, 16, 1'b1, prev);
    wait_result(64'h7766_5544_3322_1100, 4'd5, 1, 4'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
